// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for uart_tx.
// master drives the word and valid; slave is the transmitter.
interface uart_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output valid,
        input  ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic      clk,
    input logic      reset,
    uart_tx_if.slave bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_last;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    shift_d = bus.data_in;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.data_in;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            StStop: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        done_d  = (state_q == StStop) && (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at WIDTH=8, CLKS_PER_BIT=4.
// Expected serial bits come from a small frame model; outputs sampled on the falling edge.
module tb_uart_tx;

    localparam int unsigned W   = 8;
    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = W + 3;
`else
    localparam int unsigned NBITS = W + 2;
`endif
    localparam int unsigned FLEN = NBITS * CPB;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_if #(.WIDTH(W)) bus ();

    uart_tx #(
        .WIDTH       (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial line value of bit slot k of a frame carrying d.
    function automatic logic frame_bit(input logic [W-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == W + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Present a word and wait for the accepting edge.
    task automatic accept(input logic [W-1:0] d, input logic keep_valid);
        bus.data_in = d;
        bus.valid   = 1'b1;
        check("ready_before_accept", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) bus.valid = 1'b0;
    endtask

    // Called just after an accepting edge; checks every cycle up to and including the done cycle.
    task automatic expect_frame(input logic [W-1:0] d, input logic [W-1:0] mid_data,
                                input logic mid_valid, input logic end_valid);
        for (int n = 1; n <= int'(FLEN) + 1; n++) begin
            @(negedge clk);
            if (n == 12) begin
                bus.data_in = mid_data;
                bus.valid   = mid_valid;
            end
            if (n == 14) bus.valid = end_valid;
            if (n <= int'(FLEN)) begin
                check("tx_bit", 32'(bus.tx), 32'(frame_bit(d, (n - 1) / int'(CPB))));
                check("busy_in_frame", 32'(bus.busy), 32'd1);
                check("ready_in_frame", 32'(bus.ready), 32'd0);
                check("done_in_frame", 32'(bus.done), 32'd0);
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("ready_at_done", 32'(bus.ready), 32'd1);
                check("busy_at_done", 32'(bus.busy), 32'd0);
                check("tx_idle_gap", 32'(bus.tx), 32'd1);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.valid   = 1'b0;
        bus.data_in = '0;

        #1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_tx", 32'(bus.tx), 32'd1);
        check("idle_ready", 32'(bus.ready), 32'd1);

        // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
        @(negedge clk);
        accept(8'hA5, 1'b0);
        expect_frame(8'hA5, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_after_a5", 32'(bus.busy), 32'd0);

        // Back-to-back with valid held; data_in swapped to 0xC3 mid-frame.
        accept(8'h3C, 1'b1);
        expect_frame(8'h3C, 8'hC3, 1'b1, 1'b1);
        expect_frame(8'hC3, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        check("no_third_frame_busy", 32'(bus.busy), 32'd0);
        check("no_third_frame_tx", 32'(bus.tx), 32'd1);

        // Mid-frame data change and valid pulse are ignored and not queued.
        accept(8'h5A, 1'b0);
        expect_frame(8'h5A, 8'h99, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("ignored_word_busy", 32'(bus.busy), 32'd0);
            check("ignored_word_tx", 32'(bus.tx), 32'd1);
        end

        // Reset at cycle 15 of a 0xFF frame aborts it asynchronously.
        accept(8'hFF, 1'b0);
        repeat (15) @(negedge clk);
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        accept(8'h01, 1'b0);
        expect_frame(8'h01, 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range >= 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port data_in  input  WIDTH  parallel word to transmit, sampled only on acceptance.
REQ-007 Port valid  input  1  data_in holds a word to send.
REQ-008 Port ready  output  1  transmitter can accept a word; high only in IDLE.
REQ-009 Port tx  output  1  serial line; idles high; registered.
REQ-010 Port busy  output  1  frame in progress; high in START, DATA, PARITY and STOP.
REQ-011 Port done  output  1  one-cycle pulse after the stop bit completes.

Function
REQ-012 States: IDLE, START, DATA, PARITY (present only with PARITY_EN), STOP.
REQ-013 Handshake: the word is accepted on the rising edge where valid && ready; data_in is latched into the shift register and the state moves to START.
REQ-014 tx SHALL drive 0 starting the cycle after acceptance and hold it for CLKS_PER_BIT cycles.
REQ-015 DATA: WIDTH bits are sent LSB first; each bit is held exactly CLKS_PER_BIT cycles; the shift register shifts right once per bit period.
REQ-016 STOP: tx = 1 for CLKS_PER_BIT cycles, then the state returns to IDLE.
REQ-017 Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on acceptance; its width is clog2(CLKS_PER_BIT).
REQ-018 Bit index counts 0..WIDTH-1 in DATA; leaving DATA occurs at the terminal count of bit WIDTH-1.
REQ-019 Frame length from first start-bit cycle to end of stop bit: (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with PARITY_EN.
REQ-020 done = 1 for exactly the first IDLE cycle after STOP; ready is also 1 in that cycle.
REQ-021 Back-to-back: if valid is high in that first IDLE cycle, the word is accepted there, leaving exactly one idle-high tx cycle between frames.
REQ-022 valid while busy is ignored and not queued; data_in changes after acceptance do not affect the current frame.
REQ-023 Outputs ready, busy, done and tx are registered and glitch-free.

Reset
REQ-024 Reset values: state = IDLE, tx = 1, ready = 1, busy = 0, done = 0, counters = 0, shift register = 0.
REQ-025 Reset asserted mid-frame aborts the frame immediately (asynchronously); tx returns to 1 with no done pulse.
REQ-026 After reset deasserts, the first acceptance is possible on the next rising edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the PARITY state is inserted between DATA and STOP and sends even parity (XOR of the latched data bits) for CLKS_PER_BIT cycles.
REQ-028 Macro UART_TX_PARITY_EN undefined: no PARITY state or logic exists; DATA goes directly to STOP.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-029 Send 0xA5, no parity -> tx = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; done pulses 41 cycles after acceptance; busy is high for 40 cycles.
REQ-030 UART_TX_PARITY_EN, send 0xA5 -> parity bit 0 after the data bits; send 0x07 -> parity bit 1; frame is 44 cycles long.
REQ-031 valid held high with 0x3C then 0xC3 -> two frames separated by exactly one tx=1 idle cycle; done pulses twice.
REQ-032 Assert reset at cycle 15 of a 0xFF frame -> tx=1, ready=1 and busy=0 immediately; no done pulse; the next word 0x01 is sent correctly.
REQ-033 Change data_in and pulse valid mid-frame -> the transmitted bits match the originally accepted word; the second word is not sent.
